// File: rtl/hardwired_control_unit.sv
// Hardwired fetch/decode/execute sequencer: steps RST, T0..T7 and HALT,
// producing the per-step datapath control strobes from the IR opcode.
module hardwired_control_unit #(
    parameter int unsigned OPW    = 5,
    parameter logic [4:0]  INC_OP = 5'b11111,
    parameter logic [4:0]  ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir_in,
    output logic        Pen,
    output logic        Zen,
    output logic        MARen,
    output logic        MDRen,
    output logic        IRen,
    output logic        Yen,
    output logic        write,
    output logic        Pselect,
    output logic        zlowselect,
    output logic        MDRselect,
    output logic        Cselect,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_control,
    output logic        run,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_HALT, C_LD, C_LDI, C_ST, C_R, C_I
    } op_class_t;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    state_t         state_q, state_d;
    op_class_t      op_class;
    logic [OPW-1:0] op;
    logic [4:0]     imm_alu;
    logic           unused_ir;

    assign op        = ir_in[31 -: OPW];
    assign unused_ir = ^ir_in[31-OPW:0];
    assign state     = state_q;

    // Opcode class; anything undefined (including explicit nop) runs as nop.
    always_comb begin
        op_class = C_NOP;
        imm_alu  = '0;
        case (op)
            OP_LD:   op_class = C_LD;
            OP_LDI:  op_class = C_LDI;
            OP_ST:   op_class = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = C_R;
            OP_ADDI: begin op_class = C_I; imm_alu = 5'b00011; end
            OP_ANDI: begin op_class = C_I; imm_alu = 5'b00101; end
            OP_ORI:  begin op_class = C_I; imm_alu = 5'b00110; end
            OP_HALT: op_class = C_HALT;
            default: op_class = C_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= RST;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:  state_d = T0;
            T0:   state_d = T1;
            T1:   state_d = T2;
            T2:   state_d = T3;
            T3: begin
                if (op_class == C_HALT)     state_d = HALT;
                else if (op_class == C_NOP) state_d = T0;
                else                        state_d = T4;
            end
            T4:   state_d = T5;
            T5:   state_d = (op_class == C_LD || op_class == C_ST) ? T6 : T0;
            T6:   state_d = T7;
            T7:   state_d = T0;
            HALT: state_d = HALT;
            default: state_d = RST;
        endcase
    end

    always_comb begin
        Pen = 1'b0; Zen = 1'b0; MARen = 1'b0; MDRen = 1'b0; IRen = 1'b0; Yen = 1'b0;
        write = 1'b0; Pselect = 1'b0; zlowselect = 1'b0; MDRselect = 1'b0;
        Cselect = 1'b0; Read = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_control = '0;
        run = 1'b1;
        case (state_q)
            T0: begin Pselect = 1'b1; alu_control = INC_OP; Zen = 1'b1; MARen = 1'b1; end
            T1: begin zlowselect = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1; end
            T2: begin MDRselect = 1'b1; IRen = 1'b1; end
            T3: begin
                case (op_class)
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yen = 1'b1; end
                    C_R, C_I:          begin Grb = 1'b1; Rout = 1'b1; Yen = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                Zen = 1'b1;
                case (op_class)
                    C_R:     begin Grc = 1'b1; Rout = 1'b1; alu_control = op; end
                    C_I:     begin Cselect = 1'b1; alu_control = imm_alu; end
                    default: begin Cselect = 1'b1; alu_control = ADD_OP; end
                endcase
            end
            T5: begin
                zlowselect = 1'b1;
                if (op_class == C_LD || op_class == C_ST) MARen = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            T6: begin
                MDRen = 1'b1;
                if (op_class == C_ST) begin Gra = 1'b1; Rout = 1'b1; end
                else Read = 1'b1;
            end
            T7: begin
                if (op_class == C_ST) write = 1'b1;
                else begin MDRselect = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            HALT: run = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Randomized instruction-stream bench for hardwired_control_unit, checked
// against per-instruction micro-step lists built from the opcode tables.
module tb_hardwired_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir_in = '0;
    logic Pen, Zen, MARen, MDRen, IRen, Yen, write;
    logic Pselect, zlowselect, MDRselect, Cselect, Read;
    logic Gra, Grb, Grc, Rin, Rout, BAout, run;
    logic [4:0] alu_control;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    hardwired_control_unit #(.OPW(5), .INC_OP(5'b11111), .ADD_OP(5'b00011)) dut (
        .clk(clk), .clr(clr), .ir_in(ir_in),
        .Pen(Pen), .Zen(Zen), .MARen(MARen), .MDRen(MDRen), .IRen(IRen), .Yen(Yen),
        .write(write), .Pselect(Pselect), .zlowselect(zlowselect),
        .MDRselect(MDRselect), .Cselect(Cselect), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_control(alu_control), .run(run), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] M_PEN  = 18'd1 << 17, M_ZEN  = 18'd1 << 16;
    localparam logic [17:0] M_MAR  = 18'd1 << 15, M_MDR  = 18'd1 << 14;
    localparam logic [17:0] M_IR   = 18'd1 << 13, M_YEN  = 18'd1 << 12;
    localparam logic [17:0] M_WR   = 18'd1 << 11, M_PSEL = 18'd1 << 10;
    localparam logic [17:0] M_ZLO  = 18'd1 << 9,  M_MDRS = 18'd1 << 8;
    localparam logic [17:0] M_CSEL = 18'd1 << 7,  M_READ = 18'd1 << 6;
    localparam logic [17:0] M_GRA  = 18'd1 << 5,  M_GRB  = 18'd1 << 4;
    localparam logic [17:0] M_GRC  = 18'd1 << 3,  M_RIN  = 18'd1 << 2;
    localparam logic [17:0] M_ROUT = 18'd1 << 1,  M_BA   = 18'd1 << 0;

    logic [17:0] ctrl_obs;
    assign ctrl_obs = {Pen, Zen, MARen, MDRen, IRen, Yen, write, Pselect, zlowselect,
                       MDRselect, Cselect, Read, Gra, Grb, Grc, Rin, Rout, BAout};

    // Each entry: {strobe mask, alu_control} for one step, starting at T0.
    logic [22:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk)
        check("bus_onehot",
              32'($countones({Pselect, zlowselect, MDRselect, Cselect, Rout, BAout}) <= 1), 32'd1);

    task automatic build_steps(input logic [4:0] op);
        exp_q.delete();
        exp_q.push_back({M_PSEL | M_ZEN | M_MAR, 5'b11111});
        exp_q.push_back({M_ZLO | M_PEN | M_READ | M_MDR, 5'd0});
        exp_q.push_back({M_MDRS | M_IR, 5'd0});
        case (op)
            5'b00000, 5'b00001, 5'b00010: begin
                exp_q.push_back({M_GRB | M_BA | M_YEN, 5'd0});
                exp_q.push_back({M_CSEL | M_ZEN, 5'b00011});
                if (op == 5'b00001) exp_q.push_back({M_ZLO | M_GRA | M_RIN, 5'd0});
                else exp_q.push_back({M_ZLO | M_MAR, 5'd0});
                if (op == 5'b00000) begin
                    exp_q.push_back({M_READ | M_MDR, 5'd0});
                    exp_q.push_back({M_MDRS | M_GRA | M_RIN, 5'd0});
                end else if (op == 5'b00010) begin
                    exp_q.push_back({M_GRA | M_ROUT | M_MDR, 5'd0});
                    exp_q.push_back({M_WR, 5'd0});
                end
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                exp_q.push_back({M_GRB | M_ROUT | M_YEN, 5'd0});
                exp_q.push_back({M_GRC | M_ROUT | M_ZEN, op});
                exp_q.push_back({M_ZLO | M_GRA | M_RIN, 5'd0});
            end
            5'b01100, 5'b01101, 5'b01110: begin
                exp_q.push_back({M_GRB | M_ROUT | M_YEN, 5'd0});
                exp_q.push_back({M_CSEL | M_ZEN, (op == 5'b01100) ? 5'b00011 :
                                                 (op == 5'b01101) ? 5'b00101 : 5'b00110});
                exp_q.push_back({M_ZLO | M_GRA | M_RIN, 5'd0});
            end
            default: exp_q.push_back({18'd0, 5'd0});
        endcase
    endtask

    // Runs the first 'limit' steps of an instruction; IR becomes valid after T2.
    task automatic run_instr(input logic [31:0] ir, input int limit);
        logic [22:0] e;
        build_steps(ir[31:27]);
        for (int i = 0; i < exp_q.size() && i < limit; i++) begin
            @(negedge clk);
            e = exp_q[i];
            check("state", 32'(state), 32'(i + 1));
            check("strobes", 32'(ctrl_obs), 32'(e[22:5]));
            check("alu", 32'(alu_control), 32'(e[4:0]));
            check("run", 32'(run), 32'd1);
            if (i == 2) ir_in = ir;
        end
    endtask

    task automatic check_idle(input string tag, input logic [3:0] st, input logic r);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_strobes"}, 32'(ctrl_obs), 32'd0);
        check({tag, "_alu"}, 32'(alu_control), 32'd0);
        check({tag, "_run"}, 32'(run), 32'(r));
    endtask

    logic [4:0] defined_ops[11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                    5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110,
                                    5'b11010};

    initial begin
        logic [4:0] op;
        @(negedge clk);
        check_idle("reset", 4'd0, 1'b1);
        clr = 1'b0;

        run_instr(32'h0880_0005, 99);
        run_instr({5'b00000, 27'($urandom)}, 99);
        run_instr({5'b00010, 27'($urandom)}, 99);
        run_instr({5'b00100, 27'($urandom)}, 99);
        run_instr({5'b01110, 27'($urandom)}, 99);
        run_instr({5'b11111, 27'($urandom)}, 99);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) != 0) op = defined_ops[$urandom_range(10)];
            else begin
                op = 5'($urandom);
                if (op == 5'b11011) op = 5'b11100;
            end
            run_instr({op, 27'($urandom)}, 99);
        end

        // Asynchronous reset during ld T6, then a full ld.
        run_instr({5'b00000, 27'($urandom)}, 7);
        #2 clr = 1'b1;
        #1 check_idle("async_clr", 4'd0, 1'b1);
        @(negedge clk);
        check_idle("clr_held", 4'd0, 1'b1);
        clr = 1'b0;
        run_instr({5'b00000, 27'($urandom)}, 99);

        run_instr({5'b11011, 27'($urandom)}, 99);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_idle("halt", 4'd9, 1'b0);
        end
        #2 clr = 1'b1;
        #1 check_idle("halt_clr", 4'd0, 1'b1);
        @(negedge clk);
        clr = 1'b0;
        run_instr({5'b11010, 27'($urandom)}, 99);
        run_instr({5'b00001, 27'($urandom)}, 99);
        @(negedge clk);
        check("final_t0", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
